// File: rtl/spi_master.sv
// spi_master: SPI initiator for the spiMemory responder.
// Runs one 16-bit frame per transaction, MSB first: 7-bit address, R/W bit
// (1 = read), then 8 data bits (driven on mosi for a write, sampled from miso
// for a read).
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   start     transaction request, accepted only in IDLE
//   rw, addr, wdata  transaction fields, latched on accept
//   busy      high from the cycle after accept until done
//   done      one-cycle completion pulse
//   rdata     last read byte, held between reads
//   sclk_pin  SPI clock (idles high)
//   cs_pin    chip select, active low (idles high)
//   mosi_pin  serial data to responder
//   miso_pin  serial data from responder
module spi_master #(
  parameter int CLKDIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam int CW = $clog2(CLKDIV) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKDIV - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEAD = 3'd1;
  localparam logic [2:0] S_LOW  = 3'd2;
  localparam logic [2:0] S_HIGH = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    k_q, k_d;
  logic [15:0]   frame_q, frame_d;
  logic [7:0]    shadow_q, shadow_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          is_read;
  logic          cnt_zero;

  assign is_read  = frame_q[8];
  assign cnt_zero = (cnt_q == '0);

  // Next-state and divider logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    frame_d  = frame_q;
    shadow_d = shadow_q;
    rdata_d  = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          frame_d  = {addr, rw, wdata};
          k_d      = '0;
          cnt_d    = RELOAD;
          shadow_d = '0;
          state_d  = S_LEAD;
        end
      end
      S_LEAD: begin
        if (cnt_zero) begin
          cnt_d   = RELOAD;
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_LOW: begin
        if (cnt_zero) begin
          cnt_d   = RELOAD;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HIGH: begin
        if (cnt_zero) begin
          cnt_d = RELOAD;
          if (k_q == 4'd15) begin
            state_d = S_GAP;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = S_LOW;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_zero) begin
          cnt_d   = RELOAD;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        if (is_read) rdata_d = shadow_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pins are registered from the current state, so every pin change lands
    // one clk after the state change. sclk_q still low in the first HIGH
    // cycle marks the clk edge on which sclk_pin rises: miso is sampled there.
    if (state_q == S_HIGH && !sclk_q && is_read && k_q[3])
      shadow_d = {shadow_q[6:0], miso_pin};
  end

  // Registered pin values
  always_comb begin
    cs_d   = 1'b1;
    sclk_d = 1'b1;
    mosi_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      S_LEAD: begin
        cs_d   = 1'b0;
        busy_d = 1'b1;
      end
      S_LOW: begin
        cs_d   = 1'b0;
        sclk_d = 1'b0;
        busy_d = 1'b1;
        mosi_d = (is_read && k_q[3]) ? 1'b0 : frame_q[4'd15 - k_q];
      end
      S_HIGH: begin
        cs_d   = 1'b0;
        busy_d = 1'b1;
        mosi_d = mosi_q;
      end
      S_GAP: begin
        busy_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      frame_q  <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
      sclk_q   <= 1'b1;
      cs_q     <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      frame_q  <= frame_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      sclk_q   <= sclk_d;
      cs_q     <= cs_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign sclk_pin = sclk_q;
  assign cs_pin   = cs_q;
  assign mosi_pin = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master: two instances (CLKDIV=4 and CLKDIV=1), each with
// a behavioural SPI memory responder. Expected responses are queued when a
// transaction is issued; a monitor pops and compares on every done pulse.
module tb_spi_master;

  logic       clk;
  logic [1:0] rst_v;
  logic [1:0] start_v;
  logic [1:0] rw_v;
  logic [6:0] addr_v [2];
  logic [7:0] wdata_v [2];
  logic [1:0] busy_v;
  logic [1:0] done_v;
  logic [7:0] rdata_v [2];
  logic [1:0] sclk_v;
  logic [1:0] cs_v;
  logic [1:0] mosi_v;
  logic [1:0] miso_v;

  spi_master #(.CLKDIV(4)) dut0 (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .rw(rw_v[0]),
    .addr(addr_v[0]), .wdata(wdata_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .rdata(rdata_v[0]), .sclk_pin(sclk_v[0]), .cs_pin(cs_v[0]),
    .mosi_pin(mosi_v[0]), .miso_pin(miso_v[0])
  );

  spi_master #(.CLKDIV(1)) dut1 (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .rw(rw_v[1]),
    .addr(addr_v[1]), .wdata(wdata_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .rdata(rdata_v[1]), .sclk_pin(sclk_v[1]), .cs_pin(cs_v[1]),
    .mosi_pin(mosi_v[1]), .miso_pin(miso_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          dut;
    logic [15:0] frame;
    logic [7:0]  rd;
    int          dcyc;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mdl [2][128];
  logic [7:0] last_rd [2];
  int         done_cnt [2];

  logic [7:0]  rmem [2][128];
  int          rcnt [2];
  logic [15:0] rframe [2];
  logic [6:0]  raddr [2];
  logic        rrw [2];
  logic        prev_cs [2];
  logic        prev_sclk [2];
  int          hicnt [2];
  logic [15:0] last_frame [2];
  int          last_rises [2];

  function automatic int cdiv(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responder (SPI memory) and scoreboard monitor, sampled on negedge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (prev_cs[i] && !cs_v[i]) begin
        chk("cs_high_gap_ok", 32'(hicnt[i] >= cdiv(i) + 2), 32'd1);
        rcnt[i] = 0;
        rframe[i] = '0;
      end
      if (!cs_v[i]) begin
        if (!prev_sclk[i] && sclk_v[i]) begin
          rframe[i] = {rframe[i][14:0], mosi_v[i]};
          rcnt[i]++;
          if (rcnt[i] == 8) begin
            raddr[i] = rframe[i][7:1];
            rrw[i]   = rframe[i][0];
          end
        end
        if (prev_sclk[i] && !sclk_v[i]) begin
          if (rcnt[i] >= 8 && rcnt[i] < 16 && rrw[i])
            miso_v[i] = rmem[i][raddr[i]][15 - rcnt[i]];
          else
            miso_v[i] = 1'($urandom);
        end
      end
      if (!prev_cs[i] && cs_v[i]) begin
        last_frame[i] = rframe[i];
        last_rises[i] = rcnt[i];
        if (rcnt[i] == 16 && !rrw[i]) rmem[i][raddr[i]] = rframe[i][7:0];
        hicnt[i] = 0;
      end
      if (cs_v[i]) hicnt[i]++;
      prev_cs[i]   = cs_v[i];
      prev_sclk[i] = sclk_v[i];

      if (done_v[i]) begin
        done_cnt[i]++;
        if (sb.size() == 0 || sb[0].dut != i) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: dut %0d pulsed done with nothing outstanding (cycle %0d)", i, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.dcyc));
          chk("rdata_at_done", 32'(rdata_v[i]), 32'(e.rd));
          chk("mosi_frame", 32'(last_frame[i]), 32'(e.frame));
          chk("sclk_rises", 32'(last_rises[i]), 32'd16);
          chk("busy_at_done", 32'(busy_v[i]), 32'd0);
        end
      end
    end
  end

  // Drive a request at the current negedge; accept happens at the next edge.
  task automatic issue(input int i, input bit r, input logic [6:0] a,
                       input logic [7:0] d, input bit hold, input bit push,
                       output int acc);
    exp_t e;
    start_v[i] = 1'b1;
    rw_v[i]    = r;
    addr_v[i]  = a;
    wdata_v[i] = d;
    acc = cyc + 1;
    if (push) begin
      if (r) last_rd[i] = mdl[i][a];
      else   mdl[i][a]  = d;
      e.dut   = i;
      e.frame = {a, r, (r ? 8'h00 : d)};
      e.rd    = last_rd[i];
      e.dcyc  = acc + 34 * cdiv(i) + 1;
      sb.push_back(e);
    end
    if (!hold) begin
      @(negedge clk);
      start_v[i] = 1'b0;
      rw_v[i]    = 1'($urandom);
      addr_v[i]  = 7'($urandom);
      wdata_v[i] = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: %0d transactions outstanding", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_txn(input int i, input bit r, input logic [6:0] a, input logic [7:0] d);
    int acc;
    wait_idle();
    issue(i, r, a, d, 1'b0, 1'b1, acc);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("rdata_held", 32'(rdata_v[i]), 32'(last_rd[i]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, dc;
    logic [6:0] a;
    logic [7:0] d;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 128; j++) begin
        mdl[i][j]  = 8'h00;
        rmem[i][j] = 8'h00;
      end
      mdl[i][7'h55]  = 8'h92;
      rmem[i][7'h55] = 8'h92;
      last_rd[i] = 8'h00;
      done_cnt[i] = 0;
      rcnt[i] = 0;
      rframe[i] = '0;
      raddr[i] = '0;
      rrw[i] = 1'b0;
      prev_cs[i] = 1'b1;
      prev_sclk[i] = 1'b1;
      hicnt[i] = 100;
      last_frame[i] = '0;
      last_rises[i] = 0;
      addr_v[i] = '0;
      wdata_v[i] = '0;
    end
    rst_v = 2'b11;
    start_v = 2'b00;
    rw_v = 2'b00;
    miso_v = 2'b00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_cs", 32'(cs_v[i]), 32'd1);
      chk("reset_sclk", 32'(sclk_v[i]), 32'd1);
      chk("reset_mosi", 32'(mosi_v[i]), 32'd0);
      chk("reset_busy", 32'(busy_v[i]), 32'd0);
      chk("reset_done", 32'(done_v[i]), 32'd0);
      chk("reset_rdata", 32'(rdata_v[i]), 32'd0);
    end
    rst_v = 2'b00;
    repeat (2) @(negedge clk);

    // Directed write and read framing (CLKDIV=4).
    do_txn(0, 1'b0, 7'b1010101, 8'b10010010);
    do_txn(0, 1'b1, 7'b1010101, 8'h00);
    chk("read_byte", 32'(rdata_v[0]), 32'h92);

    // Reset mid-frame, during LOW of bit k=5 (frame bit 10 = addr[1] = 1).
    wait_idle();
    issue(0, 1'b0, 7'h7F, 8'h3C, 1'b0, 1'b0, acc);
    while (cyc < acc + 11 * 4 + 2) @(negedge clk);
    chk("k5_sclk_low", 32'(sclk_v[0]), 32'd0);
    chk("k5_mosi", 32'(mosi_v[0]), 32'd1);
    chk("k5_busy", 32'(busy_v[0]), 32'd1);
    dc = done_cnt[0];
    rst_v[0] = 1'b1;
    #1;
    chk("midreset_cs", 32'(cs_v[0]), 32'd1);
    chk("midreset_sclk", 32'(sclk_v[0]), 32'd1);
    chk("midreset_mosi", 32'(mosi_v[0]), 32'd0);
    chk("midreset_busy", 32'(busy_v[0]), 32'd0);
    chk("midreset_rdata", 32'(rdata_v[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b0;
    last_rd[0] = 8'h00;
    repeat (200) @(negedge clk);
    chk("no_done_after_abort", 32'(done_cnt[0]), 32'(dc));

    // Back-to-back with start held: write 0xA5 to 0x2A, then read it back.
    wait_idle();
    issue(0, 1'b0, 7'h2A, 8'hA5, 1'b1, 1'b1, acc);
    repeat (5) @(negedge clk);
    issue(0, 1'b1, 7'h2A, 8'h00, 1'b1, 1'b1, acc2);
    sb[1].dcyc = acc + 34 * 4 + 2 + 34 * 4 + 1;
    while (cyc < acc + 34 * 4 + 2) @(negedge clk);
    start_v[0] = 1'b0;
    wait_idle();
    chk("wr_then_rd", 32'(rdata_v[0]), 32'hA5);

    // Start pulsed while busy must be ignored.
    dc = done_cnt[0];
    issue(0, 1'b0, 7'h11, 8'h5A, 1'b0, 1'b1, acc);
    repeat (20) @(negedge clk);
    start_v[0] = 1'b1; rw_v[0] = 1'b0; addr_v[0] = 7'h11; wdata_v[0] = 8'hFF;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    chk("busy_start_ignored", 32'(done_cnt[0]), 32'(dc + 1));
    do_txn(0, 1'b1, 7'h11, 8'h00);

    // CLKDIV=1 corner: read, then a write leaves rdata unchanged.
    do_txn(1, 1'b1, 7'h55, 8'h00);
    chk("div1_read", 32'(rdata_v[1]), 32'h92);
    do_txn(1, 1'b0, 7'h03, 8'hC7);
    chk("div1_rdata_after_write", 32'(rdata_v[1]), 32'h92);

    // Randomized traffic on both instances over a small address set.
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 2; i++) begin
        a = 7'($urandom_range(0, 7));
        d = 8'($urandom);
        do_txn(i, 1'($urandom), a, d);
      end
    end

    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
